// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: deserializes device-to-host frames, decodes scan-code set 2
// (E0 extended, F0 break) and presents the held key as a USB HID usage code.
module ps2_keycode_rx #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       key_event,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t     state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift, shift_n;
    logic       parity_bit, parity_bit_n;
    logic [CNT_W-1:0] timeout_cnt, timeout_cnt_n;
    logic       byte_valid, byte_valid_n;
    logic       frame_err_n;
    logic       ext, brk;

    logic clk_s1, clk_s2, clk_prev;
    logic data_s1, data_s2;
    logic fall, timeout;

    // Both pins idle high, so the synchronizers reset to 1 to avoid a false edge after reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge value,
            // which is what turns this chain into a real two-stage synchronizer.
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= ps2_data;
            data_s2  <= data_s1;
        end
    end

    assign fall    = clk_prev & ~clk_s2;
    assign timeout = (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            parity_bit  <= 1'b0;
            timeout_cnt <= '0;
            byte_valid  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            shift       <= shift_n;
            parity_bit  <= parity_bit_n;
            timeout_cnt <= timeout_cnt_n;
            byte_valid  <= byte_valid_n;
            frame_err   <= frame_err_n;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_n       = state;
        bit_cnt_n     = bit_cnt;
        shift_n       = shift;
        parity_bit_n  = parity_bit;
        timeout_cnt_n = '0;
        byte_valid_n  = 1'b0;
        frame_err_n   = 1'b0;

        if (state == IDLE) begin
            if (fall && !data_s2) begin
                state_n   = DATA;
                bit_cnt_n = '0;
            end
        end else if (timeout) begin
            // A timeout wins over an edge arriving in the same cycle.
            frame_err_n = 1'b1;
            state_n     = IDLE;
        end else if (fall) begin
            unique case (state)
                DATA: begin
                    shift_n = {data_s2, shift[7:1]};
                    if (bit_cnt == 3'd7) state_n = PARITY;
                    else                 bit_cnt_n = bit_cnt + 3'd1;
                end
                PARITY: begin
                    parity_bit_n = data_s2;
                    state_n      = STOP;
                end
                STOP: begin
                    if (data_s2 && (^shift ^ parity_bit)) byte_valid_n = 1'b1;
                    else                                  frame_err_n  = 1'b1;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end else begin
            timeout_cnt_n = timeout_cnt + CNT_W'(1);
        end
    end

    // Returns {hit, hid_code}; hit=0 for codes the motion blocks do not use.
    function automatic logic [8:0] map_code(input logic is_ext, input logic [7:0] code);
        logic [8:0] r;
        r = 9'h000;
        if (!is_ext) begin
            case (code)
                8'h1C: r = 9'h104;
                8'h23: r = 9'h107;
                8'h1B: r = 9'h116;
                8'h1D: r = 9'h11A;
                8'h29: r = 9'h12C;
                default: r = 9'h000;
            endcase
        end else begin
            case (code)
                8'h75: r = 9'h152;
                8'h72: r = 9'h151;
                8'h6B: r = 9'h150;
                8'h74: r = 9'h14F;
                default: r = 9'h000;
            endcase
        end
        return r;
    endfunction

    logic [8:0] mapped;
    assign mapped = map_code(ext, shift);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ext       <= 1'b0;
            brk       <= 1'b0;
            keycode   <= 8'h00;
            key_event <= 1'b0;
        end else begin
            key_event <= 1'b0;
            if (byte_valid) begin
                if (shift == 8'hE0) begin
                    ext <= 1'b1;
                end else if (shift == 8'hF0) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (mapped[8]) begin
                        // Releasing a key other than the held one leaves the held key alone.
                        if (brk) begin
                            if (mapped[7:0] == keycode) begin
                                keycode   <= 8'h00;
                                key_event <= 1'b1;
                            end
                        end else if (mapped[7:0] != keycode) begin
                            keycode   <= mapped[7:0];
                            key_event <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule
